store_drain_buffer: RTL

Parametrised post-commit store buffer sitting between the LSU store queue and the data-memory port. It replaces the fixed word-only store path with three additions: byte/half/word stores with byte enables, byte-masked store-to-load forwarding, and speculative flush. Entries are allocated at dispatch, marked committed by the ROB, and drained in program order to memory over a req/ready handshake.

---
 rtl/core_pkg.sv | 43 ++++
 rtl/sdb_fwd_merge.sv | 75 +++++++
 rtl/store_drain_buffer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the store drain buffer
package core_pkg;

  // Widest configuration; narrower instances truncate on read.
  localparam int SDB_AW = 64;
  localparam int SDB_RW = 16;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } store_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_EXC  = 2'b10
  } drain_state_e;

  typedef struct packed {
    logic              valid;
    logic              committed;
    logic              exc;
    logic [SDB_RW-1:0] rob_idx;
    logic [SDB_AW-1:0] addr;
    logic [SDB_AW-1:0] data;
    store_size_e       size;
  } sdb_entry_t;

  localparam logic [4:0] EXC_MISALIGN_ST = 5'd1;
  localparam logic [4:0] EXC_MEM_ERROR   = 5'd3;

  function automatic logic [3:0] size_bytes(input store_size_e s);
    case (s)
      SZ_BYTE: return 4'd1;
      SZ_HALF: return 4'd2;
      SZ_WORD: return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/sdb_fwd_merge.sv
// rtl/sdb_fwd_merge.sv - byte-priority store-to-load forwarding network
module sdb_fwd_merge
  import core_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter int         XLEN     = 32,
  parameter logic [3:0] MMIO_NIB = 4'hF
) (
  input  sdb_entry_t                 entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head_idx,
  input  logic [XLEN-1:0]            fwd_addr,
  input  logic [1:0]                 fwd_size,
  output logic                       fwd_hit,
  output logic                       fwd_partial,
  output logic [XLEN-1:0]            fwd_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;

  logic [NB-1:0]   need;
  logic [NB-1:0]   got;
  logic            mmio_ovl;
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] e_addr;
  logic [XLEN-1:0] e_data;
  logic [XLEN-1:0] lb_addr;
  logic [XLEN-1:0] off;
  logic [XLEN-1:0] shifted;
  logic [3:0]      e_n;
  logic [3:0]      ld_n;
  logic [PW-1:0]   idx;

  // Oldest to youngest, so a younger entry overwrites any byte it also covers.
  always_comb begin
    need     = '0;
    got      = '0;
    mmio_ovl = 1'b0;
    merged   = '0;
    e_addr   = '0;
    e_data   = '0;
    lb_addr  = '0;
    off      = '0;
    shifted  = '0;
    e_n      = '0;
    idx      = '0;
    ld_n     = size_bytes(store_size_e'(fwd_size));
    for (int k = 0; k < NB; k++) need[k] = (4'(k) < ld_n);
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_idx + PW'(i);
      if (entries[idx].valid && !entries[idx].exc) begin
        e_addr = XLEN'(entries[idx].addr);
        e_data = XLEN'(entries[idx].data);
        e_n    = size_bytes(entries[idx].size);
        for (int k = 0; k < NB; k++) begin
          lb_addr = fwd_addr + XLEN'(k);
          off     = lb_addr - e_addr;
          if (need[k] && (off < XLEN'(e_n))) begin
            if (e_addr[XLEN-1 -: 4] == MMIO_NIB) begin
              mmio_ovl = 1'b1;
            end else begin
              got[k]           = 1'b1;
              shifted          = e_data >> {off[2:0], 3'b000};
              merged[8*k +: 8] = shifted[7:0];
            end
          end
        end
      end
    end
  end

  assign fwd_hit     = ((need & ~got) == '0) && !mmio_ovl;
  assign fwd_partial = !fwd_hit && ((got != '0) || mmio_ovl);
  assign fwd_data    = fwd_hit ? merged : '0;

endmodule

// File: rtl/store_drain_buffer.sv
// rtl/store_drain_buffer.sv - post-commit store buffer with forwarding and in-order drain; SDB_COALESCE_EN merges same-word head pairs
module store_drain_buffer
  import core_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter int         XLEN     = 32,
  parameter int         ROB_W    = 6,
  parameter logic [3:0] MMIO_NIB = 4'hF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [ROB_W-1:0]  alloc_rob_idx,
  input  logic [1:0]        alloc_size,
  input  logic [XLEN-1:0]   alloc_addr,
  input  logic [XLEN-1:0]   alloc_data,
  input  logic              commit_en,
  input  logic [ROB_W-1:0]  commit_rob_idx,
  input  logic              flush,
  input  logic [XLEN-1:0]   fwd_addr,
  input  logic [1:0]        fwd_size,
  output logic              fwd_hit,
  output logic              fwd_partial,
  output logic [XLEN-1:0]   fwd_data,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ready,
  input  logic              mem_error,
  output logic              exc_valid,
  output logic [ROB_W-1:0]  exc_rob_idx,
  output logic [4:0]        exc_cause,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  function automatic logic [NB-1:0] size_mask(input store_size_e s);
    logic [8:0] m;
    m = (9'h1 << size_bytes(s)) - 9'h1;
    return NB'(m);
  endfunction

  function automatic logic [NB-1:0] be_of(input sdb_entry_t e);
    logic [LB-1:0] sh;
    sh = e.addr[LB-1:0];
    return size_mask(e.size) << sh;
  endfunction

  function automatic logic [XLEN-1:0] lane_of(input sdb_entry_t e);
    logic [LB-1:0] sh;
    sh = e.addr[LB-1:0];
    return XLEN'(e.data) << {sh, 3'b000};
  endfunction

  function automatic logic [XLEN-1:0] bits_of(input logic [NB-1:0] be);
    logic [XLEN-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  sdb_entry_t   entries [DEPTH];
  logic [PW:0]  head, tail, count, ccnt, head_p1;
  logic [PW-1:0] h_idx, h1_idx;
  sdb_entry_t   h, h1, new_entry;
  logic [DEPTH-1:0] cmt_next;
  logic         alloc_fire, coal_ok, coal_q, start_req, exc_set;
  logic [1:0]   retire_cnt;
  logic [4:0]   exc_cause_n;
  logic [2:0]   align_mask;
  store_size_e  alloc_sz;
  drain_state_e state, state_n;
  logic [XLEN-1:0] h_addr;

  assign count       = tail - head;
  assign alloc_ready = !count[PW];
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign head_p1     = head + PTR_ONE;
  assign h_idx       = head[PW-1:0];
  assign h1_idx      = head_p1[PW-1:0];
  assign h           = entries[h_idx];
  assign h1          = entries[h1_idx];
  assign h_addr      = XLEN'(h.addr);

`ifdef SDB_COALESCE_EN
  assign coal_ok = h1.valid && h1.committed && !h1.exc && !h.exc
                && (h_addr[XLEN-1 -: 4] != MMIO_NIB)
                && (h1.addr[XLEN-1 -: 4] != MMIO_NIB)
                && (h_addr[XLEN-1:LB] == h1.addr[XLEN-1:LB]);
`else
  assign coal_ok = 1'b0;
`endif

  always_comb begin
    alloc_sz   = store_size_e'(alloc_size);
    align_mask = 3'(size_bytes(alloc_sz) - 4'd1);
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.exc       = ((alloc_addr[2:0] & align_mask) != 3'b000)
                       || ((alloc_sz == SZ_DWORD) && (XLEN == 32));
    new_entry.rob_idx   = SDB_RW'(alloc_rob_idx);
    new_entry.addr      = SDB_AW'(alloc_addr);
    new_entry.data      = SDB_AW'(alloc_data & bits_of(size_mask(alloc_sz)));
    new_entry.size      = alloc_sz;
  end

  // Commit resolves before flush so a same-cycle commit survives the squash.
  always_comb begin
    cmt_next = '0;
    ccnt     = '0;
    empty    = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cmt_next[i] = entries[i].committed
                 || (commit_en && entries[i].valid && !entries[i].committed
                     && (entries[i].rob_idx == SDB_RW'(commit_rob_idx)));
      if (entries[i].valid && cmt_next[i]) ccnt = ccnt + PTR_ONE;
      if (entries[i].valid) empty = 1'b0;
    end
  end

  always_comb begin
    state_n     = state;
    mem_req     = 1'b0;
    retire_cnt  = 2'd0;
    start_req   = 1'b0;
    exc_set     = 1'b0;
    exc_cause_n = EXC_MISALIGN_ST;
    case (state)
      ST_IDLE: begin
        if (h.valid && h.committed) begin
          if (h.exc) begin
            state_n = ST_EXC;
          end else begin
            state_n   = ST_REQ;
            start_req = 1'b1;
          end
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          retire_cnt  = coal_q ? 2'd2 : 2'd1;
          exc_set     = mem_error;
          exc_cause_n = EXC_MEM_ERROR;
          state_n     = ST_IDLE;
        end
      end
      ST_EXC: begin
        retire_cnt  = 2'd1;
        exc_set     = 1'b1;
        exc_cause_n = EXC_MISALIGN_ST;
        state_n     = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      tail        <= '0;
      coal_q      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      exc_valid   <= 1'b0;
      exc_cause   <= '0;
      exc_rob_idx <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      exc_valid <= exc_set;
      if (exc_set) begin
        exc_cause   <= exc_cause_n;
        exc_rob_idx <= ROB_W'(h.rob_idx);
      end
      if (start_req) begin
        coal_q   <= coal_ok;
        mem_addr <= {h_addr[XLEN-1:LB], {LB{1'b0}}};
        if (coal_ok) begin
          mem_be    <= be_of(h) | be_of(h1);
          mem_wdata <= (lane_of(h) & ~bits_of(be_of(h1))) | lane_of(h1);
        end else begin
          mem_be    <= be_of(h);
          mem_wdata <= lane_of(h);
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].committed <= cmt_next[i];
        if (flush && !cmt_next[i]) entries[i].valid <= 1'b0;
      end
      if (retire_cnt != 2'd0) entries[h_idx].valid  <= 1'b0;
      if (retire_cnt == 2'd2) entries[h1_idx].valid <= 1'b0;
      head <= head + (PW+1)'(retire_cnt);
      if (flush) begin
        tail <= head + ccnt;
      end else if (alloc_fire) begin
        entries[tail[PW-1:0]] <= new_entry;
        tail                  <= tail + PTR_ONE;
      end
    end
  end

  sdb_fwd_merge #(
    .DEPTH    (DEPTH),
    .XLEN     (XLEN),
    .MMIO_NIB (MMIO_NIB)
  ) u_fwd (
    .entries     (entries),
    .head_idx    (h_idx),
    .fwd_addr    (fwd_addr),
    .fwd_size    (fwd_size),
    .fwd_hit     (fwd_hit),
    .fwd_partial (fwd_partial),
    .fwd_data    (fwd_data)
  );

endmodule
